// File: rtl/sobel_pkg.sv
// Shared widths and types for the sobel output path.
// Contains no logic, so it adds no latency and has no backpressure.
package sobel_pkg;
  localparam int PIX_W        = 8;
  localparam int WORD_W       = 128;
  localparam int PIX_PER_WORD = 16;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/sobel_word_fifo.sv
// Sync show-ahead word FIFO. A push is visible on rd_data/empty one cycle later.
// Backpressure: none internally; the caller must not assert wr_en when full unless rd_en is also high.
module sobel_word_fifo
  import sobel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t wr_data,
  output logic  full,
  input  logic  rd_en,
  output word_t rd_data,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  word_t       r_mem [DEPTH];
  logic        w_pop;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/sobel_out_packer.sv
// Packs LANES-pixel beats into 128-bit words and queues them. A word is on data_out one cycle after its last beat.
// Backpressure: ready_in drains the FIFO; the input cannot be stalled, so a push into a full FIFO is dropped and flagged in overflow.
module sobel_out_packer
  import sobel_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         valid_in,
  input  logic         flush_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         overflow,
  output logic [31:0]  word_count
);
  localparam logic [4:0] LANES_W = 5'(LANES);

  logic [3:0]  r_fill;
  word_t       r_pack;
  logic        r_overflow;
  logic [31:0] r_word_count;

  word_t w_beat;
  word_t w_shifted;
  word_t w_merged;
  word_t w_rd_data;
  logic  w_complete;
  logic  w_flush_push;
  logic  w_push;
  logic  w_full;
  logic  w_empty;
  logic  w_pop;
  logic  w_wr_en;
  logic  w_unused_hi;

  assign w_unused_hi = ^data_in;

  // The pack register is zero above fill_cnt, so OR-ing in the shifted beat is enough.
  assign w_beat    = word_t'(data_in[PIX_W*LANES-1:0]);
  assign w_shifted = w_beat << {r_fill, 3'b000};
  assign w_merged  = valid_in ? (r_pack | w_shifted) : r_pack;

  assign w_complete   = valid_in && (({1'b0, r_fill} + LANES_W) == 5'(PIX_PER_WORD));
  assign w_flush_push = flush_in && (valid_in || (r_fill != 4'd0));
  assign w_push       = w_complete || w_flush_push;

  assign w_pop   = ready_in && !w_empty;
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill       <= '0;
      r_pack       <= '0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_push) begin
        r_fill <= '0;
        r_pack <= '0;
      end else if (valid_in) begin
        r_fill <= r_fill + 4'(LANES);
        r_pack <= w_merged;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_pop) r_word_count <= r_word_count + 32'd1;
    end
  end

  sobel_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (w_merged),
    .full    (w_full),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .empty   (w_empty)
  );

  assign valid_out  = !w_empty;
  assign data_out   = w_empty ? '0 : w_rd_data;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;
endmodule
